// File: rtl/riscv_demux_collector_pkg.sv
// Shared definitions for the demux collector.
// Supplies the machine word width (XLEN, overridable by a global define
// from the core configuration) and the collector state encoding.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_demux_collector_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

endpackage

// File: rtl/riscv_demux_collector.sv
// riscv_demux_collector
// Reassembles a stream of slot-tagged XLEN words into one packed bundle
// {slot N-1, ..., slot 0} and hands it off with a valid/ready handshake.
//
// Ports:
//   i_clk                rising-edge clock
//   i_rstn               asynchronous active-low reset
//   i_demux_clear        synchronous clear of all slot-valid flags (drops a FULL bundle)
//   i_demux_data         write word
//   i_demux_sel          target slot index
//   i_demux_valid        write request
//   o_demux_ready        collector accepts a write this cycle
//   o_demux_concat_data  packed slots, slot i at [XLEN*(i+1)-1 -: XLEN]
//   o_demux_slot_vld     per-slot written flags
//   o_demux_valid        all slots written, bundle available
//   i_demux_ready        consumer takes the bundle
//
// State | meaning
// ------+----------------------------------------------------------
// COLLECT | accepting writes; moves to FULL when the last flag is set
// FULL    | bundle presented; writes refused until the consumer takes it
module riscv_demux_collector
    import riscv_demux_collector_pkg::*;
#(
    parameter int N_DEMUX_OUT = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_demux_clear,
    input  logic [XLEN-1:0]                 i_demux_data,
    input  logic [$clog2(N_DEMUX_OUT)-1:0]  i_demux_sel,
    input  logic                            i_demux_valid,
    output logic                            o_demux_ready,
    output logic [N_DEMUX_OUT*XLEN-1:0]     o_demux_concat_data,
    output logic [N_DEMUX_OUT-1:0]          o_demux_slot_vld,
    output logic                            o_demux_valid,
    input  logic                            i_demux_ready
);

    localparam int SEL_W = $clog2(N_DEMUX_OUT);

    state_e                 state_q, state_d;
    logic [N_DEMUX_OUT-1:0] slot_vld_q, slot_vld_d;
    logic                   accept;

    // Clear wins over everything; a write in the same cycle is discarded.
    // Out-of-range selects (non-power-of-two N) match no slot, so they are
    // accepted but change nothing.
    always_comb begin
        state_d    = state_q;
        slot_vld_d = slot_vld_q;
        accept     = 1'b0;
        if (i_demux_clear) begin
            slot_vld_d = '0;
            state_d    = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    accept = i_demux_valid;
                    if (accept) begin
                        for (int i = 0; i < N_DEMUX_OUT; i++) begin
                            if (i_demux_sel == SEL_W'(i)) begin
                                slot_vld_d[i] = 1'b1;
                            end
                        end
                    end
                    if (&slot_vld_d) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (i_demux_ready) begin
                        slot_vld_d = '0;
                        state_d    = COLLECT;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= COLLECT;
            slot_vld_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_vld_q <= slot_vld_d;
        end
    end

    // Slot data is only loaded on an accepted write; drain and clear leave it intact.
    for (genvar g = 0; g < N_DEMUX_OUT; g++) begin : g_slot
        logic [XLEN-1:0] slot_d, slot_q;

        always_comb begin
            slot_d = slot_q;
            if (accept && (i_demux_sel == SEL_W'(g))) begin
                slot_d = i_demux_data;
            end
        end

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign o_demux_concat_data[XLEN*(g+1)-1 -: XLEN] = slot_q;
    end

    assign o_demux_slot_vld = slot_vld_q;
    assign o_demux_ready    = (state_q == COLLECT);
    assign o_demux_valid    = (state_q == FULL);

endmodule

// File: tb/tb_riscv_demux_collector.sv
module tb_riscv_demux_collector;
    import riscv_demux_collector_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic            clr4, val4, rdy_in4;
    logic [XLEN-1:0] dat4;
    logic [1:0]      sel4;
    logic            rdy4, vld4;
    logic [127:0]    cat4;
    logic [3:0]      sv4;

    // N=3 instance
    logic            clr3, val3, rdy_in3;
    logic [XLEN-1:0] dat3;
    logic [1:0]      sel3;
    logic            rdy3, vld3;
    logic [95:0]     cat3;
    logic [2:0]      sv3;

    riscv_demux_collector #(.N_DEMUX_OUT(4)) dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_demux_clear(clr4), .i_demux_data(dat4),
        .i_demux_sel(sel4), .i_demux_valid(val4), .o_demux_ready(rdy4),
        .o_demux_concat_data(cat4), .o_demux_slot_vld(sv4), .o_demux_valid(vld4),
        .i_demux_ready(rdy_in4)
    );

    riscv_demux_collector #(.N_DEMUX_OUT(3)) dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_demux_clear(clr3), .i_demux_data(dat3),
        .i_demux_sel(sel3), .i_demux_valid(val3), .o_demux_ready(rdy3),
        .o_demux_concat_data(cat3), .o_demux_slot_vld(sv3), .o_demux_valid(vld3),
        .i_demux_ready(rdy_in3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr4(input logic [1:0] s, input logic [XLEN-1:0] d);
        val4 = 1'b1; sel4 = s; dat4 = d;
        step();
        val4 = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] s, input logic [XLEN-1:0] d);
        val3 = 1'b1; sel3 = s; dat3 = d;
        step();
        val3 = 1'b0;
    endtask

    logic [127:0] full_a;
    logic [127:0] full_b;
    logic [XLEN-1:0] exp3 [3];
    logic [XLEN-1:0] rd;

    initial begin
        clr4 = 0; val4 = 0; rdy_in4 = 0; dat4 = '0; sel4 = '0;
        clr3 = 0; val3 = 0; rdy_in3 = 0; dat3 = '0; sel3 = '0;
        #12;
        check("rst_valid", 128'(vld4), 128'd0);
        check("rst_ready", 128'(rdy4), 128'd1);
        check("rst_slot_vld", 128'(sv4), 128'd0);
        check("rst_concat", cat4, 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Sequential fill
        wr4(2'd0, 32'h11111111);
        check("seq_vld0", 128'(sv4), 128'h1);
        wr4(2'd1, 32'h22222222);
        wr4(2'd2, 32'h33333333);
        check("seq_not_full", 128'(vld4), 128'd0);
        wr4(2'd3, 32'h44444444);
        full_a = 128'h44444444_33333333_22222222_11111111;
        check("seq_valid", 128'(vld4), 128'd1);
        check("seq_ready", 128'(rdy4), 128'd0);
        check("seq_concat", cat4, full_a);

        // Stall with writes presented
        rdy_in4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            val4 = 1'b1; sel4 = 2'(i); dat4 = 32'hBAD00000 + i;
            step();
            check("stall_concat", cat4, full_a);
            check("stall_ready", 128'(rdy4), 128'd0);
            check("stall_valid", 128'(vld4), 128'd1);
        end
        val4 = 1'b0;
        rdy_in4 = 1'b1;
        step();
        rdy_in4 = 1'b0;
        check("drain_valid", 128'(vld4), 128'd0);
        check("drain_slot_vld", 128'(sv4), 128'd0);
        check("drain_ready", 128'(rdy4), 128'd1);
        check("drain_retained", cat4, full_a);

        // Out-of-order fill with rewrite
        wr4(2'd2, 32'hA);
        check("ooo_vld1", 128'(sv4), 128'b0100);
        wr4(2'd0, 32'hB);
        check("ooo_vld2", 128'(sv4), 128'b0101);
        wr4(2'd2, 32'hC);
        check("ooo_vld3", 128'(sv4), 128'b0101);
        wr4(2'd3, 32'hD);
        check("ooo_vld4", 128'(sv4), 128'b1101);
        check("ooo_not_full", 128'(vld4), 128'd0);
        wr4(2'd1, 32'hE);
        check("ooo_vld5", 128'(sv4), 128'b1111);
        check("ooo_valid", 128'(vld4), 128'd1);
        full_b = {32'hD, 32'hC, 32'hE, 32'hB};
        check("ooo_concat", cat4, full_b);
        rdy_in4 = 1'b1;
        step();
        rdy_in4 = 1'b0;
        check("ooo_drain", 128'(vld4), 128'd0);

        // Clear during collection with a simultaneous write to slot 3
        wr4(2'd0, 32'h1);
        wr4(2'd1, 32'h2);
        wr4(2'd2, 32'h3);
        check("clr_pre_vld", 128'(sv4), 128'b0111);
        clr4 = 1'b1;
        val4 = 1'b1; sel4 = 2'd3; dat4 = 32'h99;
        step();
        clr4 = 1'b0; val4 = 1'b0;
        check("clr_slot_vld", 128'(sv4), 128'd0);
        check("clr_valid", 128'(vld4), 128'd0);
        check("clr_ready", 128'(rdy4), 128'd1);
        check("clr_concat", cat4, {32'hD, 32'h3, 32'h2, 32'h1});
        step();
        check("clr_no_full", 128'(vld4), 128'd0);

        // Clear drops a FULL bundle
        wr4(2'd3, 32'h4);
        wr4(2'd0, 32'h5);
        wr4(2'd1, 32'h6);
        wr4(2'd2, 32'h7);
        check("clr_full_pre", 128'(vld4), 128'd1);
        clr4 = 1'b1;
        step();
        clr4 = 1'b0;
        check("clr_full_valid", 128'(vld4), 128'd0);
        check("clr_full_vld", 128'(sv4), 128'd0);

        // Async reset while FULL
        wr4(2'd0, 32'hF0);
        wr4(2'd1, 32'hF1);
        wr4(2'd2, 32'hF2);
        wr4(2'd3, 32'hF3);
        check("ar_pre_valid", 128'(vld4), 128'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_valid", 128'(vld4), 128'd0);
        check("ar_ready", 128'(rdy4), 128'd1);
        check("ar_concat", cat4, 128'd0);
        check("ar_slot_vld", 128'(sv4), 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // N=3: out-of-range select dropped, then round trip
        wr3(2'd0, 32'h100);
        check("n3_vld0", 128'(sv3), 128'b001);
        wr3(2'd3, 32'hDEAD);
        check("n3_oor_vld", 128'(sv3), 128'b001);
        check("n3_oor_concat", 128'(cat3), 128'(96'h100));
        check("n3_oor_ready", 128'(rdy3), 128'd1);
        exp3[0] = 32'h100;
        exp3[1] = 32'hCAFE0001;
        exp3[2] = 32'h12345678;
        wr3(2'd1, exp3[1]);
        check("n3_not_full", 128'(vld3), 128'd0);
        wr3(2'd2, exp3[2]);
        check("n3_valid", 128'(vld3), 128'd1);
        for (int i = 0; i < 3; i++) begin
            rd = cat3[XLEN*i +: XLEN];
            check("n3_roundtrip", 128'(rd), 128'(exp3[i]));
        end
        rdy_in3 = 1'b1;
        step();
        rdy_in3 = 1'b0;
        check("n3_drain", 128'(vld3), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
